// File: rtl/shift_reg_feed_ctrl.sv
// shift_reg_feed_ctrl: sequencer for ROWS shift_reg instances that feed one edge of a systolic array.
// A pass is one parallel LOAD of every row, then LENGTH READ rotations per row, so each row ends
// rotated back to its loaded order.
// Optional feature macro FEED_SKEW_EN:
//   defined   -> row r's READ window starts r cycles after row 0's, giving a diagonal wavefront.
//   undefined -> all rows READ together, as a broadcast feed.
// Ports:
//   clk, reset_n  clock; synchronous active-low reset
//   start         requests a pass; only sampled in IDLE
//   abort         cancels a pass in progress; takes priority over start
//   ready / busy  IDLE / (LOAD, FEED or DONE)
//   ctrl_code     2 bits per row, row r at [2r+1:2r]: 0=UPLOAD (idle), 1=LOAD, 3=READ
//   row_valid     row r's data_read is valid this cycle
//   done          one-cycle pulse when a pass completes
module shift_reg_feed_ctrl #(
  parameter int ROWS   = 4,
  parameter int LENGTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  output logic              ready,
  output logic              busy,
  output logic [2*ROWS-1:0] ctrl_code,
  output logic [ROWS-1:0]   row_valid,
  output logic              done
);

  localparam int CNT_W = $clog2(LENGTH + ROWS);
`ifdef FEED_SKEW_EN
  localparam int FEED_T = LENGTH + ROWS - 1;
`else
  localparam int FEED_T = LENGTH;
`endif
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FEED_T - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_FEED = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [ROWS-1:0]  row_rd;
  int               cnt_i;

  assign cnt_i = int'(cnt);

  // Which rows are inside their READ window this cycle. Derived from state/cnt
  // only, so it feeds both ctrl_code and the registered row_valid.
  always_comb begin
    row_rd = '0;
    for (int r = 0; r < ROWS; r++) begin
`ifdef FEED_SKEW_EN
      row_rd[r] = (state == S_FEED) && (cnt_i >= r) && (cnt_i <= r + LENGTH - 1);
`else
      row_rd[r] = (state == S_FEED) && (cnt_i <= LENGTH - 1);
`endif
    end
  end

  // State register, feed counter and the valid pipeline stage.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      row_valid <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      // Delayed one cycle to line up with shift_reg's data_read; an abort
      // drops the valid of the READ issued in the aborting cycle as well.
      row_valid <= abort ? '0 : row_rd;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (start && !abort) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        cnt_nxt   = '0;
        state_nxt = abort ? S_IDLE : S_FEED;
      end
      S_FEED: begin
        if (abort) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        // start is deliberately not looked at here; it is taken from IDLE.
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode from registers only.
  always_comb begin
    ready     = (state == S_IDLE);
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    ctrl_code = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (state == S_LOAD)  ctrl_code[2*r +: 2] = 2'd1;
      else if (row_rd[r])   ctrl_code[2*r +: 2] = 2'd3;
      else                  ctrl_code[2*r +: 2] = 2'd0;
    end
  end

endmodule
